data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`timescale 1ns/1ps
// Request/response structures shared between the core memory stage and
// the data memory controller.
package data_mem_ctrl_pkg;
  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;
endpackage

// data_mem_ctrl: single-ported word/byte data memory with fixed response
// latency and valid/yumi handshakes on both the request and response side.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    from_mem_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned words_lp = 1 << addr_width_p;
  localparam logic [3:0]  lat_m1_lp = 4'(latency_p - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [addr_width_p-1:0] idx_q;
  logic [1:0]              lane_q;
  logic                    wen_q, bnw_q;
  logic [31:0]             read_data_q;
  logic                    err_q;

  logic [31:0]             mem [words_lp];

  logic [addr_width_p-1:0] req_idx;
  logic [1:0]              req_lane;
  logic                    take;
  logic                    load_resp;

  logic [addr_width_p-1:0] sel_idx;
  logic [1:0]              sel_lane;
  logic                    sel_wen, sel_bnw;
  logic [31:0]             rd_word, rd_shift, resp_data;

  // Upper address bits are deliberately ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:addr_width_p+2];

  assign req_idx  = addr_i[addr_width_p+1:2];
  assign req_lane = addr_i[1:0];

  // Gated by reset so an asserted reset never acknowledges or writes.
  assign take = (state_q == IDLE) && to_mem_i.valid && reset;

  // With latency 1 the read happens on the accepting edge, so the live
  // request fields are used instead of the not-yet-latched copies.
  assign sel_idx  = (state_q == IDLE) ? req_idx                 : idx_q;
  assign sel_lane = (state_q == IDLE) ? req_lane                : lane_q;
  assign sel_wen  = (state_q == IDLE) ? to_mem_i.wen            : wen_q;
  assign sel_bnw  = (state_q == IDLE) ? to_mem_i.byte_not_word  : bnw_q;

  assign rd_word  = mem[sel_idx];
  assign rd_shift = rd_word >> {sel_lane, 3'b000};
  assign resp_data = sel_wen ? '0 :
                     sel_bnw ? {24'h0, rd_shift[7:0]} : rd_word;

  // Next-state, countdown and read-strobe decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          cnt_d = lat_m1_lp;
          if (latency_p == 1) begin
            state_d   = RESP;
            load_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d     = '0;
          state_d   = RESP;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (to_mem_i.yumi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, latched request fields, response data and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      wen_q       <= 1'b0;
      bnw_q       <= 1'b0;
      read_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q  <= req_idx;
        lane_q <= req_lane;
        wen_q  <= to_mem_i.wen;
        bnw_q  <= to_mem_i.byte_not_word;
        if (!to_mem_i.byte_not_word && (req_lane != 2'b00)) err_q <= 1'b1;
      end
      if (load_resp) read_data_q <= resp_data;
    end
  end

  // Storage array: written on the accepting edge, never reset.
  always_ff @(posedge clk) begin
    if (take && to_mem_i.wen) begin
      if (to_mem_i.byte_not_word)
        mem[req_idx][{req_lane, 3'b000} +: 8] <= to_mem_i.write_data[7:0];
      else
        mem[req_idx] <= to_mem_i.write_data;
    end
  end

  assign from_mem_o.read_data = read_data_q;
  assign from_mem_o.valid     = (state_q == RESP);
  assign from_mem_o.yumi      = take;
  assign busy_o               = (state_q != IDLE);
  assign err_o                = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
// Bench for data_mem_ctrl: three instances (latency 2, 1, 4) driven with
// directed and random word/byte traffic against an array model.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  mem_in_s     req    [3];
  logic [31:0] addr_s [3];
  mem_out_s    resp   [3];
  logic        busy   [3];
  logic        err    [3];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat_p [3] = '{2, 1, 4};

  logic [31:0] mdl   [3][1024];
  bit          err_m [3];

  data_mem_ctrl #(.addr_width_p(10), .latency_p(2)) u_l2 (
    .clk(clk), .reset(rst_n), .to_mem_i(req[0]), .addr_i(addr_s[0]),
    .from_mem_o(resp[0]), .busy_o(busy[0]), .err_o(err[0]));
  data_mem_ctrl #(.addr_width_p(10), .latency_p(1)) u_l1 (
    .clk(clk), .reset(rst_n), .to_mem_i(req[1]), .addr_i(addr_s[1]),
    .from_mem_o(resp[1]), .busy_o(busy[1]), .err_o(err[1]));
  data_mem_ctrl #(.addr_width_p(10), .latency_p(4)) u_l4 (
    .clk(clk), .reset(rst_n), .to_mem_i(req[2]), .addr_i(addr_s[2]),
    .from_mem_o(resp[2]), .busy_o(busy[2]), .err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: word-addressed array, index from bits [11:2], lane [1:0].
  function automatic logic [31:0] model_op(input int i, input logic wen, input logic bnw,
                                           input logic [31:0] addr, input logic [31:0] wd);
    int unsigned idx  = addr[11:2];
    int unsigned lane = addr[1:0];
    logic [31:0] w;
    if (!bnw && lane != 0) err_m[i] = 1'b1;
    if (wen) begin
      if (bnw) begin
        w = mdl[i][idx];
        w[lane*8 +: 8] = wd[7:0];
        mdl[i][idx] = w;
      end else begin
        mdl[i][idx] = wd;
      end
      return 32'h0;
    end
    w = mdl[i][idx];
    if (bnw) return {24'h0, w[lane*8 +: 8]};
    return w;
  endfunction

  task automatic drive(input int i, input logic wen, input logic bnw,
                       input logic [31:0] addr, input logic [31:0] wd);
    req[i].valid         = 1'b1;
    req[i].wen           = wen;
    req[i].byte_not_word = bnw;
    req[i].write_data    = wd;
    addr_s[i]            = addr;
  endtask

  // Wait for response valid; lat counts negedges after the accepting edge.
  task automatic wait_valid(input int i, output int lat, output logic [31:0] rd);
    lat = 0;
    rd  = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); #1;
      if (resp[i].valid === 1'b1) begin
        lat = n;
        rd  = resp[i].read_data;
        break;
      end
    end
  endtask

  // One complete transaction with the core yumiing the response at once.
  task automatic run_op(input int i, input string tag, input logic wen, input logic bnw,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] exp, rd;
    int lat, n;
    @(negedge clk);
    drive(i, wen, bnw, addr, wd);
    req[i].yumi = 1'b1;
    #1;
    n = 0;
    while (resp[i].yumi !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_req_yumi"}, {31'h0, resp[i].yumi}, 32'h1);
    exp = model_op(i, wen, bnw, addr, wd);
    @(posedge clk); #1;
    req[i].valid = 1'b0;
    wait_valid(i, lat, rd);
    check({tag, "_latency"}, lat, lat_p[i]);
    check({tag, "_data"}, rd, exp);
  endtask

  initial begin
    logic [31:0] a, wd, rd0, exp, rd;
    int lat;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i]    = '0;
      addr_s[i] = '0;
      err_m[i]  = 1'b0;
    end
    req[0].valid = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", {31'h0, resp[i].valid}, 32'h0);
      check("rst_yumi",  {31'h0, resp[i].yumi},  32'h0);
      check("rst_rdata", resp[i].read_data,       32'h0);
      check("rst_busy",  {31'h0, busy[i]},        32'h0);
      check("rst_err",   {31'h0, err[i]},         32'h0);
    end
    req[0].valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word store then load.
    run_op(0, "wst10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    run_op(0, "wld10", 1'b0, 1'b0, 32'h10, 32'h0);
    check("wld10_const", mdl[0][4], 32'hDEADBEEF);

    // Byte store/load within a word.
    run_op(0, "wst20", 1'b1, 1'b0, 32'h20, 32'h11223344);
    run_op(0, "bst22", 1'b1, 1'b1, 32'h22, 32'h5A5A5AAA);
    run_op(0, "wld20", 1'b0, 1'b0, 32'h20, 32'h0);
    run_op(0, "bld23", 1'b0, 1'b1, 32'h23, 32'h0);
    check("wld20_const", mdl[0][8], 32'h11AA3344);

    // Misaligned word load and address wrap.
    run_op(0, "mis13", 1'b0, 1'b0, 32'h13, 32'h0);
    check("mis13_err", {31'h0, err[0]}, 32'h1);
    run_op(0, "alias_ld", 1'b0, 1'b0, 32'h1010, 32'h0);
    run_op(0, "alias_st", 1'b1, 1'b0, 32'h1010, 32'hCAFEF00D);
    run_op(0, "alias_ck", 1'b0, 1'b0, 32'h10, 32'h0);

    // Prefill a window on every instance, then random mixed traffic.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 64; w++) begin
        a = $urandom;
        a[11:0] = 12'(w << 2);
        run_op(i, "fill", 1'b1, 1'b0, a, $urandom);
      end
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 30; k++) begin
        logic wen_r, bnw_r;
        wen_r = 1'($urandom_range(0, 1));
        bnw_r = 1'($urandom_range(0, 1));
        a = $urandom;
        a[11:2] = 10'($urandom_range(0, 63));
        if (!bnw_r) a[1:0] = 2'b00;
        wd = $urandom;
        run_op(i, "rand", wen_r, bnw_r, a, wd);
      end
    for (int i = 0; i < 3; i++) check("err_after_rand", {31'h0, err[i]}, {31'h0, err_m[i]});

    // Response held for 5 cycles while a second request waits.
    @(negedge clk);
    req[0].yumi = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h20, 32'h0);
    #1;
    check("hold_req_yumi", {31'h0, resp[0].yumi}, 32'h1);
    exp = model_op(0, 1'b0, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #1;
    req[0].valid = 1'b0;
    wait_valid(0, lat, rd0);
    check("hold_latency", lat, 32'd2);
    check("hold_data", rd0, exp);
    drive(0, 1'b1, 1'b0, 32'h30, 32'h600DD00D);
    #1;
    for (int h = 0; h < 5; h++) begin
      if (h > 0) begin
        @(negedge clk); #1;
      end
      check("hold_valid",  {31'h0, resp[0].valid}, 32'h1);
      check("hold_stable", resp[0].read_data, rd0);
      check("hold_no_yumi", {31'h0, resp[0].yumi}, 32'h0);
    end
    @(negedge clk);
    req[0].yumi = 1'b1;
    #1;
    check("yumi_cycle_no_accept", {31'h0, resp[0].yumi}, 32'h0);
    check("yumi_cycle_valid", {31'h0, resp[0].valid}, 32'h1);
    @(negedge clk); #1;
    check("accept_after_yumi", {31'h0, resp[0].yumi}, 32'h1);
    check("idle_valid_low", {31'h0, resp[0].valid}, 32'h0);
    exp = model_op(0, 1'b1, 1'b0, 32'h30, 32'h600DD00D);
    @(posedge clk); #1;
    req[0].valid = 1'b0;
    wait_valid(0, lat, rd);
    check("second_latency", lat, 32'd2);
    check("second_data", rd, exp);
    run_op(0, "second_ld", 1'b0, 1'b0, 32'h30, 32'h0);

    // Async reset while a load is waiting.
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    check("arst_req_yumi", {31'h0, resp[0].yumi}, 32'h1);
    @(posedge clk); #1;
    req[0].valid = 1'b0;
    #1;
    check("arst_busy_before", {31'h0, busy[0]}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy",  {31'h0, busy[0]},        32'h0);
    check("arst_valid", {31'h0, resp[0].valid},  32'h0);
    check("arst_err",   {31'h0, err[0]},         32'h0);
    check("arst_rdata", resp[0].read_data,       32'h0);
    for (int i = 0; i < 3; i++) err_m[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, "post_st", 1'b1, 1'b1, 32'h31, 32'h000000EE);
    run_op(0, "post_ld", 1'b0, 1'b0, 32'h30, 32'h0);
    run_op(2, "post_ld4", 1'b0, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 3; i++) check("err_final", {31'h0, err[i]}, {31'h0, err_m[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
